// File: rtl/lfsr_mask_scheduler_pkg.sv
// Shared constants, FSM encoding and the LFSR next-state function for the mask scheduler.
// Both the scheduler and its LFSR register unit import this package.
package lfsr_mask_scheduler_pkg;

   localparam int LFSR_W = 20;

   localparam int TAP_A = 15;
   localparam int TAP_B = 11;
   localparam int TAP_C = 7;
   localparam int TAP_D = 0;

   localparam logic [LFSR_W-1:0] DEFAULT_SEED = 20'h99999;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Right-shifting Fibonacci step: new bit enters at the MSB.
   function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] s);
      return {s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D], s[LFSR_W-1:1]};
   endfunction

endpackage

// File: rtl/lfsr_mask_scheduler_step_unit.sv
// LFSR state register with external step/load control and an all-zero lockup guard.
// A load has priority over a step in the same cycle.
module lfsr_step_unit
   import lfsr_mask_scheduler_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              step,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_val,
   output logic [LFSR_W-1:0] value
);

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= SEED;
      end else if (load) begin
         // An all-zero state would never leave zero, so substitute the seed.
         value <= (load_val == '0) ? SEED : load_val;
      end else if (step) begin
         value <= lfsr_advance(value);
      end
   end

endmodule

// File: rtl/lfsr_mask_scheduler.sv
// Round-robin scheduler sharing one LFSR among NUM_REQ key requesters; one granted
// key is XORed with the low LFSR byte, each bit widened to a byte, and held until accepted.
module lfsr_mask_scheduler
   import lfsr_mask_scheduler_pkg::*;
#(
   parameter int              NUM_REQ = 4,
   parameter int              ID_W    = 2,
   parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_key,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [63:0]          out_load,
   output logic [ID_W-1:0]      out_id,
   input  logic                 seed_load,
   input  logic [LFSR_W-1:0]    seed_val,
   output logic [15:0]          issue_cnt
);

   state_t            state;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   winner;
   logic              found;
   logic              grant;
   logic              handshake;
   logic [7:0]        key_w;
   logic [63:0]       load_next;
   logic [LFSR_W-1:0] lfsr_val;

   lfsr_step_unit #(.SEED(SEED)) u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .step     (handshake),
      .load     (seed_load),
      .load_val (seed_val),
      .value    (lfsr_val)
   );

   // First requesting index at or after rr_ptr, wrapping around.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
            found  = 1'b1;
            winner = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
         end
      end
   end

   assign grant     = (state == IDLE) && !seed_load && found;
   assign handshake = (state == HOLD) && out_valid && out_ready;
   assign req_ready = (grant && !rst) ? (NUM_REQ'(1) << winner) : '0;
   assign key_w     = req_key[{winner, 3'b000} +: 8];

   always_comb begin
      load_next = '0;
      for (int i = 0; i < 8; i++) begin
         load_next[8*i +: 8] = {8{key_w[i] ^ lfsr_val[i]}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         out_valid <= 1'b0;
         out_load  <= '0;
         out_id    <= '0;
         issue_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  out_load  <= load_next;
                  out_id    <= winner;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  issue_cnt <= issue_cnt + 16'd1;
                  rr_ptr    <= (out_id == ID_W'(NUM_REQ - 1)) ? '0 : out_id + ID_W'(1);
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
